// File: rtl/term_pkg.sv
// Shared constants, FSM state encoding and cursor operation codes for the
// terminal byte sequencer.
package term_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_PUT,
        ST_ADVANCE,
        ST_SCROLL,
        ST_SCROLL_WAIT,
        ST_CLEAR,
        ST_CLEAR_WAIT
    } state_t;

    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_INC,
        CUR_DEC,
        CUR_COL0,
        CUR_ROW_INC,
        CUR_HOME
    } cur_op_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/term_cursor.sv
// Cursor position register; all arithmetic clamps so col < COLS and row < ROWS.
module term_cursor
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  cur_op_t                 i_op,
    output logic [$clog2(COLS)-1:0] o_col,
    output logic [$clog2(ROWS)-1:0] o_row,
    output logic                    o_last_col,
    output logic                    o_last_row
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    assign o_last_col = (o_col == CW'(COLS - 1));
    assign o_last_row = (o_row == RW'(ROWS - 1));

    // Wrapping past the bottom row leaves row at ROWS-1; the scroll itself is
    // the sequencer's job.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_col <= '0;
            o_row <= '0;
        end else begin
            case (i_op)
                CUR_INC: begin
                    if (!o_last_col) begin
                        o_col <= o_col + CW'(1);
                    end else begin
                        o_col <= '0;
                        if (!o_last_row) o_row <= o_row + RW'(1);
                    end
                end
                CUR_DEC: begin
                    if (o_col != '0) o_col <= o_col - CW'(1);
                end
                CUR_COL0: o_col <= '0;
                CUR_ROW_INC: begin
                    if (!o_last_row) o_row <= o_row + RW'(1);
                end
                CUR_HOME: begin
                    o_col <= '0;
                    o_row <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/term_seq.sv
// Terminal byte sequencer: decodes received bytes into VRAM character writes,
// cursor moves, scroll requests and screen clears.
module term_seq
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_data,
    output logic                    o_rx_ready,
    output logic                    o_put_start,
    output logic [7:0]              o_put_char,
    output logic [$clog2(COLS)-1:0] o_col,
    output logic [$clog2(ROWS)-1:0] o_row,
    output logic                    o_scroll_start,
    input  logic                    i_scroll_done,
    output logic                    o_clear_start,
    input  logic                    i_clear_done,
    output logic                    o_busy,
    output state_t                  o_state
);

    state_t  state;
    state_t  next_state;
    cur_op_t cur_op;
    logic    [7:0] rx_byte;
    logic    last_col;
    logic    last_row;
    logic    accept;

    // Handshake: a byte transfers on a rising edge where i_rx_valid and
    // o_rx_ready are both high; i_rx_data is only looked at on that edge.
    assign accept     = i_rx_valid && o_rx_ready;
    assign o_put_char = rx_byte;
    assign o_state    = state;

    term_cursor #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_cursor (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_op      (cur_op),
        .o_col     (o_col),
        .o_row     (o_row),
        .o_last_col(last_col),
        .o_last_row(last_row)
    );

    always_comb begin
        next_state = state;
        cur_op     = CUR_HOLD;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_printable(rx_byte)) begin
                    next_state = ST_PUT;
                end else begin
                    next_state = ST_IDLE;
                    case (rx_byte)
                        CH_CR: cur_op = CUR_COL0;
                        CH_LF: begin
                            if (last_row) next_state = ST_SCROLL;
                            else          cur_op     = CUR_ROW_INC;
                        end
                        CH_BS: cur_op = CUR_DEC;
                        CH_FF: next_state = ST_CLEAR;
                        default: ;
                    endcase
                end
            end
            ST_PUT: next_state = ST_ADVANCE;
            ST_ADVANCE: begin
                cur_op     = CUR_INC;
                next_state = (last_col && last_row) ? ST_SCROLL : ST_IDLE;
            end
            ST_SCROLL: next_state = ST_SCROLL_WAIT;
            ST_SCROLL_WAIT: begin
                if (i_scroll_done) next_state = ST_IDLE;
            end
            ST_CLEAR: next_state = ST_CLEAR_WAIT;
            ST_CLEAR_WAIT: begin
                if (i_clear_done) begin
                    cur_op     = CUR_HOME;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered decodes of next_state; ready additionally needs a
    // full cycle already spent in IDLE, so it is low while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            rx_byte        <= 8'h00;
            o_rx_ready     <= 1'b0;
            o_put_start    <= 1'b0;
            o_scroll_start <= 1'b0;
            o_clear_start  <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            state          <= next_state;
            if (accept) rx_byte <= i_rx_data;
            o_rx_ready     <= (state == ST_IDLE) && (next_state == ST_IDLE);
            o_put_start    <= (next_state == ST_PUT);
            o_scroll_start <= (next_state == ST_SCROLL);
            o_clear_start  <= (next_state == ST_CLEAR);
            o_busy         <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_term_seq.sv
// Bench for term_seq: reset checks, a vector table, directed corner sequences
// and a randomized byte stream against a cursor/event reference model.
module tb_term_seq;
    import term_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int PW   = 8 + CW + RW;
    localparam int LIMIT = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          scroll_done = 1'b0;
    logic          clear_done = 1'b0;
    logic          rx_ready, put_start, scroll_start, clear_start, busy;
    logic [7:0]    put_char;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    state_t        dbg_state;

    always #5 clk = ~clk;

    term_seq #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_ready(rx_ready), .o_put_start(put_start), .o_put_char(put_char),
        .o_col(col), .o_row(row), .o_scroll_start(scroll_start),
        .i_scroll_done(scroll_done), .o_clear_start(clear_start),
        .i_clear_done(clear_done), .o_busy(busy), .o_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_put = 0, n_scroll = 0, n_clear = 0, n_multi = 0;
    logic [PW-1:0] act_q[$];
    logic [PW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (put_start === 1'b1) begin
            n_put++;
            act_q.push_back({put_char, col, row});
        end
        if (scroll_start === 1'b1) n_scroll++;
        if (clear_start === 1'b1) n_clear++;
        if ((int'(put_start === 1'b1) + int'(scroll_start === 1'b1) + int'(clear_start === 1'b1)) > 1)
            n_multi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; scroll_done = 1'b0; clear_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        act_q.delete();
        exp_q.delete();
    endtask

    // Sends one byte, answers scroll/clear requests after dly cycles (optionally
    // with a stray done in the start cycle) and returns cycles until ready again.
    task automatic send(input logic [7:0] b, input int dly, input bit stray,
                        output int t, output int busy_n);
        int w, sd, cd;
        w = 0;
        while (!rx_ready && w < LIMIT) begin tick(); w++; end
        check($sformatf("ready_before_%02h", b), 32'(rx_ready), 32'd1);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
        sd = 0; cd = 0; t = 0; busy_n = 0;
        while (!rx_ready && t < LIMIT) begin
            if (busy) busy_n++;
            scroll_done = 1'b0; clear_done = 1'b0;
            if (sd > 0) begin sd--; if (sd == 0) scroll_done = 1'b1; end
            if (cd > 0) begin cd--; if (cd == 0) clear_done = 1'b1; end
            if (scroll_start) begin sd = dly; if (stray) scroll_done = 1'b1; end
            if (clear_start)  begin cd = dly; if (stray) clear_done = 1'b1; end
            tick();
            t++;
        end
        scroll_done = 1'b0; clear_done = 1'b0;
        check($sformatf("ready_after_%02h", b), 32'(rx_ready), 32'd1);
    endtask

    task automatic goto_from_home(input int c, input int r);
        int t, bn;
        repeat (r) send(CH_LF, 1, 1'b0, t, bn);
        repeat (c) send(8'h78, 1, 1'b0, t, bn);
    endtask

    typedef struct {
        logic [7:0]    b;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        int            puts;
        int            scrolls;
        int            clears;
    } vec_t;

    vec_t vecs[14];

    initial begin : main
        int t, bn, p0, s0, c0, w, mc, mr, r, dly;
        logic [7:0] b;
        logic [PW-1:0] a, e;
        bit stray;
        logic [5:1] rdy_seen, put_seen;
        logic [5:1] exp_rdy;
        logic [PW-1:0] put_rec;

        vecs[0]  = '{8'h41, 7'd1, 5'd0, 1, 0, 0};
        vecs[1]  = '{8'h42, 7'd2, 5'd0, 1, 0, 0};
        vecs[2]  = '{CH_BS, 7'd1, 5'd0, 0, 0, 0};
        vecs[3]  = '{CH_BS, 7'd0, 5'd0, 0, 0, 0};
        vecs[4]  = '{CH_BS, 7'd0, 5'd0, 0, 0, 0};
        vecs[5]  = '{CH_LF, 7'd0, 5'd1, 0, 0, 0};
        vecs[6]  = '{8'h7A, 7'd1, 5'd1, 1, 0, 0};
        vecs[7]  = '{8'h7E, 7'd2, 5'd1, 1, 0, 0};
        vecs[8]  = '{8'h20, 7'd3, 5'd1, 1, 0, 0};
        vecs[9]  = '{8'h1F, 7'd3, 5'd1, 0, 0, 0};
        vecs[10] = '{8'h7F, 7'd3, 5'd1, 0, 0, 0};
        vecs[11] = '{CH_CR, 7'd0, 5'd1, 0, 0, 0};
        vecs[12] = '{CH_FF, 7'd0, 5'd0, 0, 0, 1};
        vecs[13] = '{8'h80, 7'd0, 5'd0, 0, 0, 0};

        // Reset values while reset is held, then ready in the first cycle after.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_put", 32'(put_start), 32'd0);
        check("rst_scroll", 32'(scroll_start), 32'd0);
        check("rst_clear", 32'(clear_start), 32'd0);
        check("rst_col", 32'(col), 32'd0);
        check("rst_row", 32'(row), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_char", 32'(put_char), 32'h00);
        rst = 1'b0;
        tick();
        check("rst_release_ready", 32'(rx_ready), 32'd1);

        // 'A' held valid: put in the second cycle, ready back four edges later.
        act_q.delete();
        p0 = n_put;
        exp_rdy = 5'b10000;
        rx_valid = 1'b1; rx_data = 8'h41;
        for (int k = 1; k <= 5; k++) begin
            tick();
            rdy_seen[k] = rx_ready;
            put_seen[k] = put_start;
        end
        rx_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("lat_ready_c%0d", k), 32'(rdy_seen[k]), 32'(exp_rdy[k]));
        end
        check("lat_put_c2", 32'(put_seen[2]), 32'd1);
        repeat (3) tick();
        check("lat_put_count", 32'(n_put - p0), 32'd1);
        put_rec = (act_q.size() > 0) ? act_q.pop_front() : '1;
        check("lat_put_rec", 32'(put_rec), 32'({8'h41, 7'd0, 5'd0}));
        check("lat_col_after", 32'(col), 32'd1);

        // Vector table from home.
        do_reset();
        foreach (vecs[i]) begin
            p0 = n_put; s0 = n_scroll; c0 = n_clear;
            send(vecs[i].b, 2, 1'b0, t, bn);
            check($sformatf("vec%0d_col", i), 32'(col), 32'(vecs[i].col));
            check($sformatf("vec%0d_row", i), 32'(row), 32'(vecs[i].row));
            check($sformatf("vec%0d_puts", i), 32'(n_put - p0), 32'(vecs[i].puts));
            check($sformatf("vec%0d_scrolls", i), 32'(n_scroll - s0), 32'(vecs[i].scrolls));
            check($sformatf("vec%0d_clears", i), 32'(n_clear - c0), 32'(vecs[i].clears));
        end

        // Wrap at the right edge without scrolling.
        do_reset();
        goto_from_home(79, 5);
        act_q.delete();
        s0 = n_scroll;
        send(8'h42, 1, 1'b0, t, bn);
        put_rec = (act_q.size() > 0) ? act_q.pop_front() : '1;
        check("wrap_put_rec", 32'(put_rec), 32'({8'h42, 7'd79, 5'd5}));
        check("wrap_col", 32'(col), 32'd0);
        check("wrap_row", 32'(row), 32'd6);
        check("wrap_scrolls", 32'(n_scroll - s0), 32'd0);

        // Wrap at the bottom-right corner: scroll, done 20 cycles later.
        goto_from_home(79, 23);
        act_q.delete();
        s0 = n_scroll;
        send(8'h43, 20, 1'b0, t, bn);
        put_rec = (act_q.size() > 0) ? act_q.pop_front() : '1;
        check("corner_put_rec", 32'(put_rec), 32'({8'h43, 7'd79, 5'd29}));
        check("corner_scrolls", 32'(n_scroll - s0), 32'd1);
        check("corner_cycles", 32'(t), 32'd25);
        check("corner_busy_cycles", 32'(bn), 32'd24);
        check("corner_col", 32'(col), 32'd0);
        check("corner_row", 32'(row), 32'd29);

        // BS at col 0, CR at col 10, LF on the last row, then a discarded byte.
        do_reset();
        send(CH_BS, 1, 1'b0, t, bn);
        check("bs_col0", 32'(col), 32'd0);
        goto_from_home(10, 0);
        check("cr_pre_col", 32'(col), 32'd10);
        send(CH_CR, 1, 1'b0, t, bn);
        check("cr_col", 32'(col), 32'd0);
        goto_from_home(0, 29);
        check("lf_pre_row", 32'(row), 32'd29);
        s0 = n_scroll;
        send(CH_LF, 3, 1'b0, t, bn);
        check("lf_scrolls", 32'(n_scroll - s0), 32'd1);
        check("lf_row", 32'(row), 32'd29);
        p0 = n_put; s0 = n_scroll; c0 = n_clear;
        send(8'h07, 3, 1'b0, t, bn);
        check("bel_pulses", 32'((n_put - p0) + (n_scroll - s0) + (n_clear - c0)), 32'd0);
        check("bel_col", 32'(col), 32'd0);
        check("bel_row", 32'(row), 32'd29);

        // FF at (12,7) with a stray done in the clear start cycle.
        do_reset();
        goto_from_home(12, 7);
        c0 = n_clear;
        send(CH_FF, 5, 1'b1, t, bn);
        check("ff_clears", 32'(n_clear - c0), 32'd1);
        check("ff_cycles", 32'(t), 32'd8);
        check("ff_col", 32'(col), 32'd0);
        check("ff_row", 32'(row), 32'd0);

        // Reset during SCROLL_WAIT, late done pulse afterwards.
        do_reset();
        goto_from_home(4, 29);
        rx_valid = 1'b1; rx_data = CH_LF;
        tick();
        rx_valid = 1'b0;
        w = 0;
        while (!scroll_start && w < 20) begin tick(); w++; end
        check("rstw_scroll_start", 32'(scroll_start), 32'd1);
        repeat (3) tick();
        check("rstw_in_wait", 32'(dbg_state), 32'(ST_SCROLL_WAIT));
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        p0 = n_put; s0 = n_scroll; c0 = n_clear;
        scroll_done = 1'b1;
        tick();
        scroll_done = 1'b0;
        repeat (5) tick();
        check("rstw_pulses", 32'((n_put - p0) + (n_scroll - s0) + (n_clear - c0)), 32'd0);
        check("rstw_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rstw_col", 32'(col), 32'd0);
        check("rstw_row", 32'(row), 32'd0);
        check("rstw_ready", 32'(rx_ready), 32'd1);
        check("rstw_busy", 32'(busy), 32'd0);

        // Random byte stream against the reference model.
        do_reset();
        mc = 0; mr = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = 8'($urandom_range(32, 126));
            else if (r < 75) b = CH_LF;
            else if (r < 80) b = CH_CR;
            else if (r < 86) b = CH_BS;
            else if (r < 88) b = CH_FF;
            else             b = 8'($urandom_range(0, 1) ? $urandom_range(127, 255) : $urandom_range(0, 7));
            dly = $urandom_range(1, 6);
            stray = ($urandom_range(0, 3) == 0);
            s0 = n_scroll; c0 = n_clear;
            r = 0;
            w = 0;
            if (b >= 8'h20 && b <= 8'h7E) begin
                exp_q.push_back({b, CW'(mc), RW'(mr)});
                if (mc < COLS - 1) mc++;
                else begin
                    mc = 0;
                    if (mr < ROWS - 1) mr++; else r = 1;
                end
            end else if (b == CH_CR) mc = 0;
            else if (b == CH_LF) begin
                if (mr < ROWS - 1) mr++; else r = 1;
            end else if (b == CH_BS) begin
                if (mc > 0) mc--;
            end else if (b == CH_FF) begin
                mc = 0; mr = 0; w = 1;
            end
            send(b, dly, stray, t, bn);
            check($sformatf("rnd%0d_col", i), 32'(col), 32'(mc));
            check($sformatf("rnd%0d_row", i), 32'(row), 32'(mr));
            check($sformatf("rnd%0d_scrolls", i), 32'(n_scroll - s0), 32'(r));
            check($sformatf("rnd%0d_clears", i), 32'(n_clear - c0), 32'(w));
            check($sformatf("rnd%0d_putq", i), 32'(act_q.size()), 32'(exp_q.size()));
            while (act_q.size() > 0 && exp_q.size() > 0) begin
                a = act_q.pop_front();
                e = exp_q.pop_front();
                check($sformatf("rnd%0d_put", i), 32'(a), 32'(e));
            end
            act_q.delete();
            exp_q.delete();
        end

        check("pulse_onehot", 32'(n_multi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/term_seq.md
TERM_SEQ -- requirements
Module: term_seq

Interface
REQ-001 Parameter COLS, default 80: text columns per row.
REQ-002 Parameter ROWS, default 30: text rows per screen.
REQ-003 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_rx_valid  in  1  received byte available.
REQ-006 i_rx_data  in  8  received byte.
REQ-007 o_rx_ready  out  1  byte accepted on an edge where i_rx_valid and o_rx_ready are both high.
REQ-008 o_put_start  out  1  one-cycle pulse requesting a VRAM character write.
REQ-009 o_put_char  out  8  character to write; valid while o_put_start is high.
REQ-010 o_col  out  $clog2(COLS)  cursor column.
REQ-011 o_row  out  $clog2(ROWS)  cursor row.
REQ-012 o_scroll_start  out  1  one-cycle pulse requesting a one-row scroll-up.
REQ-013 i_scroll_done  in  1  one-cycle pulse: scroll finished.
REQ-014 o_clear_start  out  1  one-cycle pulse requesting a full screen clear.
REQ-015 i_clear_done  in  1  one-cycle pulse: clear finished.
REQ-016 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have these states: IDLE, DECODE, PUT, ADVANCE, SCROLL, SCROLL_WAIT, CLEAR, CLEAR_WAIT.
REQ-018 o_rx_ready SHALL be high only in IDLE; on acceptance, the FSM latches i_rx_data and moves to DECODE.
REQ-019 DECODE, one cycle, acts on the latched byte:
  - 0x20-0x7E: go to PUT.
  - 0x0D (CR): col=0; go to IDLE.
  - 0x0A (LF): if row<ROWS-1, row+1 and go to IDLE; else go to SCROLL.
  - 0x08 (BS): col-1, saturating at 0; go to IDLE.
  - 0x0C (FF): go to CLEAR.
  - any other byte: discarded; go to IDLE.
REQ-020 PUT SHALL last one cycle with o_put_start=1, o_put_char=latched byte, and o_col/o_row at the pre-advance cursor; then go to ADVANCE.
REQ-021 ADVANCE:
  - if col<COLS-1: col+1; go to IDLE.
  - else: col=0; if row<ROWS-1, row+1 and go to IDLE; else go to SCROLL.
REQ-022 SCROLL SHALL last one cycle with o_scroll_start=1, then go to SCROLL_WAIT; the row stays at ROWS-1.
REQ-023 SCROLL_WAIT SHALL hold until i_scroll_done=1, then go to IDLE; this wait has no timeout.
REQ-024 CLEAR SHALL last one cycle with o_clear_start=1, then go to CLEAR_WAIT.
REQ-025 CLEAR_WAIT SHALL hold until i_clear_done=1; then col=0, row=0, and go to IDLE.
REQ-026 i_scroll_done and i_clear_done SHALL be ignored outside their wait states, including a done pulse in the same cycle as the matching start pulse.
REQ-027 Printable-byte latency: acceptance at edge E0; o_put_start high in the cycle after E0+1; o_rx_ready high again 4 cycles after E0.
REQ-028 At most one of o_put_start, o_scroll_start, o_clear_start SHALL be high in any cycle.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-030 Cursor arithmetic SHALL never produce col>=COLS or row>=ROWS.

Reset
REQ-031 On i_rst=1, at the next edge: state=IDLE, col=0, row=0, latched byte=0x00, and o_put_start, o_scroll_start, o_clear_start, o_busy all 0.
REQ-032 o_rx_ready SHALL be 0 in any cycle where i_rst=1, and SHALL be 1 in the first cycle after reset deasserts.
REQ-033 Reset mid-operation, including during SCROLL_WAIT or CLEAR_WAIT, SHALL abandon the operation; a done pulse arriving after reset is ignored.

Structure
REQ-034 Shared package term_pkg SHALL hold:
  - the COLS/ROWS defaults;
  - the control-code constants CR, LF, BS, FF;
  - the printable-range bounds;
  - the FSM state encoding.
REQ-035 Cursor storage and update (hold, inc-with-wrap, dec-sat, col-zero, home) SHALL be the sub-module term_cursor; term_seq holds only the FSM and the byte latch.

Verification
REQ-036 Reset, then "A" (0x41) held valid: o_put_start high in exactly one cycle with o_put_char=0x41, col=0, row=0; afterwards col=1, and o_rx_ready returns 4 cycles after acceptance.
REQ-037 Cursor at col=79, row=5; send 0x42: write at (79,5); cursor becomes (0,6); no o_scroll_start.
REQ-038 Cursor at col=79, row=29; send 0x43: write at (79,29), then one o_scroll_start pulse; busy and o_rx_ready=0 until i_scroll_done is pulsed 20 cycles later; cursor ends at (0,29).
REQ-039 Sequence BS at col=0, CR at col=10, LF at row=29, 0x07, in that order:
  - BS: col stays 0.
  - CR: col becomes 0.
  - LF: one scroll.
  - 0x07: discarded, no pulse.
REQ-040 Send FF with the cursor at (12,7):
  - One o_clear_start pulse.
  - A stray i_clear_done in the start cycle is ignored.
  - A later i_clear_done returns the FSM to IDLE with the cursor at (0,0).
REQ-041 i_rst asserted during SCROLL_WAIT, then i_scroll_done pulsed after release: state IDLE, cursor (0,0), no further pulses, o_rx_ready=1.
